// File: rtl/sc_level_sequencer_pkg.sv
// Frogger level sequencer: shared state codes.
// Imported by the sequencer top and its bus interface.
package sc_level_seq_pkg;

  localparam int SEQ_STATE_WIDTH = 3;

  localparam logic [SEQ_STATE_WIDTH-1:0] CODE_IDLE      = 3'd0;
  localparam logic [SEQ_STATE_WIDTH-1:0] CODE_PLAY      = 3'd1;
  localparam logic [SEQ_STATE_WIDTH-1:0] CODE_LEVEL_UP  = 3'd2;
  localparam logic [SEQ_STATE_WIDTH-1:0] CODE_DEATH     = 3'd3;
  localparam logic [SEQ_STATE_WIDTH-1:0] CODE_GAME_OVER = 3'd4;
  localparam logic [SEQ_STATE_WIDTH-1:0] CODE_WIN       = 3'd5;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    S_IDLE      = CODE_IDLE,
    S_PLAY      = CODE_PLAY,
    S_LEVEL_UP  = CODE_LEVEL_UP,
    S_DEATH     = CODE_DEATH,
    S_GAME_OVER = CODE_GAME_OVER,
    S_WIN       = CODE_WIN
  } seq_state_t;

endpackage

// File: rtl/sc_level_sequencer_if.sv
// Frogger level sequencer: game-event and status bus.
// master = game side / bench, slave = sequencer.
import sc_level_seq_pkg::*;

interface sc_level_sequencer_if #(
  parameter int LEVEL_WIDTH = 8,
  parameter int LIVES_WIDTH = 2
);

  logic                       SC_LEVEL_SEQ_start_InLow;
  logic                       SC_LEVEL_SEQ_goal_InLow;
  logic                       SC_LEVEL_SEQ_crash_InLow;
  logic [LEVEL_WIDTH-1:0]     SC_LEVEL_SEQ_level_In;
  logic                       SC_LEVEL_SEQ_levelUp_OutLow;
  logic                       SC_LEVEL_SEQ_levelClear_OutHigh;
  logic                       SC_LEVEL_SEQ_frogReset_OutHigh;
  logic [LIVES_WIDTH-1:0]     SC_LEVEL_SEQ_lives_Out;
  logic [SEQ_STATE_WIDTH-1:0] SC_LEVEL_SEQ_state_Out;
  logic                       SC_LEVEL_SEQ_play_OutHigh;
  logic                       SC_LEVEL_SEQ_gameOver_OutHigh;
  logic                       SC_LEVEL_SEQ_win_OutHigh;

  modport master (
    output SC_LEVEL_SEQ_start_InLow,
    output SC_LEVEL_SEQ_goal_InLow,
    output SC_LEVEL_SEQ_crash_InLow,
    output SC_LEVEL_SEQ_level_In,
    input  SC_LEVEL_SEQ_levelUp_OutLow,
    input  SC_LEVEL_SEQ_levelClear_OutHigh,
    input  SC_LEVEL_SEQ_frogReset_OutHigh,
    input  SC_LEVEL_SEQ_lives_Out,
    input  SC_LEVEL_SEQ_state_Out,
    input  SC_LEVEL_SEQ_play_OutHigh,
    input  SC_LEVEL_SEQ_gameOver_OutHigh,
    input  SC_LEVEL_SEQ_win_OutHigh
  );

  modport slave (
    input  SC_LEVEL_SEQ_start_InLow,
    input  SC_LEVEL_SEQ_goal_InLow,
    input  SC_LEVEL_SEQ_crash_InLow,
    input  SC_LEVEL_SEQ_level_In,
    output SC_LEVEL_SEQ_levelUp_OutLow,
    output SC_LEVEL_SEQ_levelClear_OutHigh,
    output SC_LEVEL_SEQ_frogReset_OutHigh,
    output SC_LEVEL_SEQ_lives_Out,
    output SC_LEVEL_SEQ_state_Out,
    output SC_LEVEL_SEQ_play_OutHigh,
    output SC_LEVEL_SEQ_gameOver_OutHigh,
    output SC_LEVEL_SEQ_win_OutHigh
  );

endinterface

// File: rtl/sc_level_sequencer_edge_detect_low.sv
// Falling-edge detector for an active-low button/level.
// History clears in reset so a held-low input fires nothing.
module sc_edge_detect_low (
  input  logic SC_EDGE_CLOCK_50,
  input  logic SC_EDGE_RESET_InLow,
  input  logic SC_EDGE_sig_InLow,
  output logic SC_EDGE_event_OutHigh
);

  logic s;
  logic prev;

  // Sample the input, then keep one cycle of history.
  always_ff @(posedge SC_EDGE_CLOCK_50) begin
    if (!SC_EDGE_RESET_InLow) begin
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      s    <= SC_EDGE_sig_InLow;
      prev <= s;
    end
  end

  assign SC_EDGE_event_OutHigh = prev & ~s;

endmodule

// File: rtl/sc_level_sequencer.sv
// Frogger game-flow controller: level counter control,
// lives tracking, respawn pulses and pause windows.
import sc_level_seq_pkg::*;

module sc_level_sequencer #(
  parameter int LEVEL_WIDTH  = 8,
  parameter int MAX_LEVEL    = 5,
  parameter int LIVES_WIDTH  = 2,
  parameter int LIVES_INIT   = 3,
  parameter int PAUSE_CYCLES = 25_000_000,
  parameter int PAUSE_WIDTH  = 25
) (
  input  logic SC_LEVEL_SEQ_CLOCK_50,
  input  logic SC_LEVEL_SEQ_RESET_InLow,
  sc_level_sequencer_if.slave bus
);

  localparam logic [LEVEL_WIDTH-1:0] LVL_MAX =
    LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LIVES_WIDTH-1:0] LIV_INIT =
    LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LIV_ONE =
    LIVES_WIDTH'(1);
  localparam logic [PAUSE_WIDTH-1:0] T_LAST =
    PAUSE_WIDTH'(PAUSE_CYCLES - 1);
  localparam logic [PAUSE_WIDTH-1:0] T_ONE =
    PAUSE_WIDTH'(1);

  logic start_ev;
  logic goal_ev;
  logic crash_ev;

  seq_state_t             state;
  logic [LIVES_WIDTH-1:0] lives;
  logic [PAUSE_WIDTH-1:0] timer;
  logic                   rst_hist;
  logic                   up_q;
  logic                   clr_q;
  logic                   frog_q;
  logic                   play_q;
  logic                   go_q;
  logic                   win_q;

  sc_edge_detect_low u_start (
    .SC_EDGE_CLOCK_50      (SC_LEVEL_SEQ_CLOCK_50),
    .SC_EDGE_RESET_InLow   (SC_LEVEL_SEQ_RESET_InLow),
    .SC_EDGE_sig_InLow     (bus.SC_LEVEL_SEQ_start_InLow),
    .SC_EDGE_event_OutHigh (start_ev)
  );

  sc_edge_detect_low u_goal (
    .SC_EDGE_CLOCK_50      (SC_LEVEL_SEQ_CLOCK_50),
    .SC_EDGE_RESET_InLow   (SC_LEVEL_SEQ_RESET_InLow),
    .SC_EDGE_sig_InLow     (bus.SC_LEVEL_SEQ_goal_InLow),
    .SC_EDGE_event_OutHigh (goal_ev)
  );

  sc_edge_detect_low u_crash (
    .SC_EDGE_CLOCK_50      (SC_LEVEL_SEQ_CLOCK_50),
    .SC_EDGE_RESET_InLow   (SC_LEVEL_SEQ_RESET_InLow),
    .SC_EDGE_sig_InLow     (bus.SC_LEVEL_SEQ_crash_InLow),
    .SC_EDGE_event_OutHigh (crash_ev)
  );

  // Game FSM with lives, pause timer and registered outputs.
  always_ff @(posedge SC_LEVEL_SEQ_CLOCK_50) begin
    if (!SC_LEVEL_SEQ_RESET_InLow) begin
      state    <= S_IDLE;
      lives    <= LIV_INIT;
      timer    <= '0;
      rst_hist <= 1'b1;
      up_q     <= 1'b1;
      clr_q    <= 1'b1;
      frog_q   <= 1'b1;
      play_q   <= 1'b0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      // Counter clear stretches one cycle past reset.
      rst_hist <= 1'b0;
      clr_q    <= rst_hist;
      up_q     <= 1'b1;
      frog_q   <= 1'b0;
      case (state)
        S_IDLE, S_GAME_OVER, S_WIN: begin
          if (start_ev) begin
            state  <= S_PLAY;
            lives  <= LIV_INIT;
            clr_q  <= 1'b1;
            frog_q <= 1'b1;
            play_q <= 1'b1;
            go_q   <= 1'b0;
            win_q  <= 1'b0;
          end
        end
        S_PLAY: begin
          // Crash outranks a same-cycle goal.
          if (crash_ev) begin
            play_q <= 1'b0;
            if (lives > LIV_ONE) begin
              state  <= S_DEATH;
              lives  <= lives - LIV_ONE;
              frog_q <= 1'b1;
            end else begin
              state <= S_GAME_OVER;
              lives <= '0;
              go_q  <= 1'b1;
            end
          end else if (goal_ev) begin
            play_q <= 1'b0;
            if (bus.SC_LEVEL_SEQ_level_In < LVL_MAX) begin
              state  <= S_LEVEL_UP;
              up_q   <= 1'b0;
              frog_q <= 1'b1;
            end else begin
              state <= S_WIN;
              win_q <= 1'b1;
            end
          end
        end
        S_LEVEL_UP, S_DEATH: begin
          if (timer == T_LAST) begin
            timer  <= '0;
            state  <= S_PLAY;
            play_q <= 1'b1;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        default: begin
          state  <= S_IDLE;
          timer  <= '0;
          play_q <= 1'b0;
          go_q   <= 1'b0;
          win_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SC_LEVEL_SEQ_levelUp_OutLow     = up_q;
  assign bus.SC_LEVEL_SEQ_levelClear_OutHigh = clr_q;
  assign bus.SC_LEVEL_SEQ_frogReset_OutHigh  = frog_q;
  assign bus.SC_LEVEL_SEQ_lives_Out          = lives;
  assign bus.SC_LEVEL_SEQ_state_Out          = state;
  assign bus.SC_LEVEL_SEQ_play_OutHigh       = play_q;
  assign bus.SC_LEVEL_SEQ_gameOver_OutHigh   = go_q;
  assign bus.SC_LEVEL_SEQ_win_OutHigh        = win_q;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Directed bench for sc_level_sequencer with a
// level-counter model and an expectation queue.
module tb_sc_level_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] level;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  sc_level_sequencer_if #(
    .LEVEL_WIDTH (8),
    .LIVES_WIDTH (2)
  ) bus ();

  sc_level_sequencer #(
    .LEVEL_WIDTH  (8),
    .MAX_LEVEL    (5),
    .LIVES_WIDTH  (2),
    .LIVES_INIT   (3),
    .PAUSE_CYCLES (4),
    .PAUSE_WIDTH  (3)
  ) dut (
    .SC_LEVEL_SEQ_CLOCK_50    (clk),
    .SC_LEVEL_SEQ_RESET_InLow (rst_n),
    .bus                      (bus)
  );

  always #5 clk = ~clk;

  // Level counter: active-high clear, active-low increment.
  always @(posedge clk) begin
    if (bus.SC_LEVEL_SEQ_levelClear_OutHigh === 1'b1)
      level <= 8'd0;
    else if (bus.SC_LEVEL_SEQ_levelUp_OutLow === 1'b0)
      level <= level + 8'd1;
  end

  assign bus.SC_LEVEL_SEQ_level_In = level;

  function automatic logic [31:0] obs(string t);
    if (t == "state")
      return 32'(bus.SC_LEVEL_SEQ_state_Out);
    else if (t == "lives")
      return 32'(bus.SC_LEVEL_SEQ_lives_Out);
    else if (t == "play")
      return 32'(bus.SC_LEVEL_SEQ_play_OutHigh);
    else if (t == "clr")
      return 32'(bus.SC_LEVEL_SEQ_levelClear_OutHigh);
    else if (t == "up")
      return 32'(bus.SC_LEVEL_SEQ_levelUp_OutLow);
    else if (t == "frog")
      return 32'(bus.SC_LEVEL_SEQ_frogReset_OutHigh);
    else if (t == "go")
      return 32'(bus.SC_LEVEL_SEQ_gameOver_OutHigh);
    else if (t == "win")
      return 32'(bus.SC_LEVEL_SEQ_win_OutHigh);
    else if (t == "level")
      return 32'(level);
    return 'x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic want(string t, int v);
    exp_t e;
    e.tag = t;
    e.exp = 32'(v);
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.tag);
      total++;
      assert (o === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d",
               e.tag, o, e.exp);
      end
    end
  endtask

  // m[0]=start m[1]=goal m[2]=crash; ends at edge k+1.
  task automatic press(logic [2:0] m);
    bus.SC_LEVEL_SEQ_start_InLow = ~m[0];
    bus.SC_LEVEL_SEQ_goal_InLow  = ~m[1];
    bus.SC_LEVEL_SEQ_crash_InLow = ~m[2];
    step();
    bus.SC_LEVEL_SEQ_start_InLow = 1'b1;
    bus.SC_LEVEL_SEQ_goal_InLow  = 1'b1;
    bus.SC_LEVEL_SEQ_crash_InLow = 1'b1;
    step();
  endtask

  // Called at the first pause cycle; walks to PLAY.
  task automatic pause(int code, int lvl);
    step();
    want("state", code);
    want("up", 1);
    want("frog", 0);
    want("level", lvl);
    check_sb();
    for (int i = 0; i < 2; i++) begin
      step();
      want("state", code);
      check_sb();
    end
    step();
    want("state", 1);
    want("play", 1);
    check_sb();
  endtask

  task automatic goal_up(int lvl);
    want("state", 2);
    want("up", 0);
    want("frog", 1);
    want("play", 0);
    press(3'b010);
    check_sb();
    pause(2, lvl + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.SC_LEVEL_SEQ_start_InLow = 1'b1;
    bus.SC_LEVEL_SEQ_goal_InLow  = 1'b1;
    bus.SC_LEVEL_SEQ_crash_InLow = 1'b1;

    // Reset for three cycles.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      want("clr", 1);
      check_sb();
    end
    want("state", 0);
    want("lives", 3);
    want("play", 0);
    want("up", 1);
    want("frog", 1);
    check_sb();
    rst_n = 1'b1;
    step();
    want("clr", 1);
    want("frog", 0);
    want("state", 0);
    check_sb();
    step();
    want("clr", 0);
    want("level", 0);
    check_sb();

    // Start the game.
    want("state", 1);
    want("play", 1);
    want("clr", 1);
    want("frog", 1);
    want("lives", 3);
    press(3'b001);
    check_sb();
    step();
    want("clr", 0);
    want("frog", 0);
    check_sb();

    // Start ignored while playing.
    want("state", 1);
    want("clr", 0);
    press(3'b001);
    check_sb();

    // Climb to level 3.
    for (int l = 0; l < 3; l++)
      goal_up(l);

    // Three crashes.
    want("state", 3);
    want("lives", 2);
    want("frog", 1);
    want("play", 0);
    press(3'b100);
    check_sb();
    pause(3, 3);
    want("state", 3);
    want("lives", 1);
    press(3'b100);
    check_sb();
    pause(3, 3);
    want("state", 4);
    want("lives", 0);
    want("go", 1);
    want("play", 0);
    want("frog", 0);
    press(3'b100);
    check_sb();

    // Crash ignored in GAME_OVER.
    want("state", 4);
    want("lives", 0);
    press(3'b100);
    check_sb();

    // Restart from GAME_OVER.
    want("state", 1);
    want("clr", 1);
    want("lives", 3);
    want("go", 0);
    press(3'b001);
    check_sb();
    step();
    want("level", 0);
    check_sb();
    want("lives", 2);
    press(3'b100);
    check_sb();
    pause(3, 0);

    // Goal and crash together: crash wins.
    want("state", 3);
    want("lives", 1);
    want("up", 1);
    press(3'b110);
    check_sb();
    pause(3, 0);

    // Reach level 5, then win.
    for (int l = 0; l < 5; l++)
      goal_up(l);
    want("state", 5);
    want("win", 1);
    want("up", 1);
    want("play", 0);
    press(3'b010);
    check_sb();
    step();
    want("level", 5);
    check_sb();
    want("state", 5);
    press(3'b010);
    check_sb();

    // New game from WIN.
    want("state", 1);
    want("clr", 1);
    want("lives", 3);
    want("win", 0);
    want("play", 1);
    press(3'b001);
    check_sb();
    step();
    want("level", 0);
    check_sb();

    // Reset in the middle of a LEVEL_UP pause.
    want("state", 2);
    press(3'b010);
    check_sb();
    step();
    rst_n = 1'b0;
    step();
    want("state", 0);
    want("clr", 1);
    want("up", 1);
    want("play", 0);
    want("lives", 3);
    check_sb();
    rst_n = 1'b1;
    step();
    step();
    want("state", 0);
    want("clr", 0);
    want("level", 0);
    check_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
